jump_controller: RTL

JUMP_CONTROLLER -- requirements
Module: jump_controller

---
 rtl/jump_controller.sv | 123 ++++++++++++
 1 files changed

// File: rtl/jump_controller.sv
// Frame-stepped jump controller: launches the sprite upward at V0, decelerates
// by GRAVITY each frame, and reports landing back on the ground row.
module jump_controller #(
    parameter int unsigned V0       = 8,
    parameter int unsigned GRAVITY  = 1,
    parameter int unsigned Y_GROUND = 400
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        frame_tick,
    input  logic        jump_req,
    output logic        count_en,
    output logic [31:0] max,
    output logic [9:0]  y_pos,
    output logic        airborne,
    output logic        land_pulse
);

    localparam int unsigned YW = 10;
    localparam int unsigned AW = 11;
    localparam int unsigned VW = 8;

    localparam logic [YW-1:0]        Y_GND      = YW'(Y_GROUND);
    localparam logic signed [AW-1:0] Y_GND_S    = $signed({1'b0, Y_GND});
    localparam logic signed [VW:0]   VEL_MIN    = -$signed((VW+1)'(2 ** (VW - 1)));
    localparam logic [31:0]          MAX_FRAMES = 32'((2 * V0) / GRAVITY + 1);

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        FALL,
        LAND
    } state_e;

    state_e                state_q, state_d;
    logic [YW-1:0]         y_q, y_d;
    logic signed [VW-1:0]  vel_q, vel_d;
    logic                  airborne_q, airborne_d;
    logic                  land_q, land_d;

    logic signed [AW-1:0]  y_ext;
    logic signed [AW-1:0]  y_next;
    logic [YW-1:0]         y_next_clamped;
    logic signed [VW:0]    vel_dec;
    logic signed [VW-1:0]  vel_sat;

    // Next-state and datapath; velocity arithmetic carries one extra bit so
    // saturation at the negative limit can be detected before truncation.
    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        vel_d      = vel_q;
        land_d     = 1'b0;

        y_ext          = $signed({1'b0, y_q});
        y_next         = y_ext - AW'(vel_q);
        y_next_clamped = y_next[AW-1] ? '0 : YW'(y_next);
        vel_dec        = (VW+1)'(vel_q) - $signed((VW+1)'(GRAVITY));
        vel_sat        = (vel_dec < VEL_MIN) ? VW'(VEL_MIN) : VW'(vel_dec);

        unique case (state_q)
            IDLE: begin
                if (frame_tick && jump_req) begin
                    state_d = RISE;
                    vel_d   = VW'(V0);
                end
            end
            RISE: begin
                if (frame_tick) begin
                    y_d   = y_next_clamped;
                    vel_d = vel_sat;
                    if (vel_dec[VW] || (vel_dec == '0)) begin
                        state_d = FALL;
                    end
                end
            end
            FALL: begin
                if (frame_tick) begin
                    if (y_next >= Y_GND_S) begin
                        y_d     = Y_GND;
                        vel_d   = '0;
                        state_d = LAND;
                        land_d  = 1'b1;
                    end else begin
                        y_d   = y_next_clamped;
                        vel_d = vel_sat;
                    end
                end
            end
            LAND: begin
                if (!jump_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        airborne_d = (state_d == RISE) || (state_d == FALL);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            y_q        <= Y_GND;
            vel_q      <= '0;
            airborne_q <= 1'b0;
            land_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            vel_q      <= vel_d;
            airborne_q <= airborne_d;
            land_q     <= land_d;
        end
    end

    assign y_pos      = y_q;
    assign airborne   = airborne_q;
    assign count_en   = airborne_q;
    assign land_pulse = land_q;
    assign max        = MAX_FRAMES;

endmodule
